vend_controller: RTL and testbench

Transaction sequencer for the vending machine. Holds a per-slot price/supply table and accepts one customer request at a time through a valid/ready handshake. For each request it checks affordability, stock and cash-box capacity, then either dispenses units one by one and returns change, or rejects with a full refund and the red light. It owns the machine account that the customer datapath previously received as an input.

---
 rtl/vend_controller.sv | 119 +++++++++++
 tb/tb_vend_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// vend_controller: vending transaction sequencer owning the price/supply table and machine account.
// Accepts one request at a time, checks it, then dispenses with change or rejects with a full refund.
module vend_controller #(
    parameter int N_SLOTS  = 4,
    parameter int VAL_W    = 4,
    parameter int ACC_W    = 5,
    parameter int DISP_CYC = 2,
    parameter int SLOT_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [VAL_W-1:0]  cfg_price,
    input  logic [VAL_W-1:0]  cfg_supply,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SLOT_W-1:0] req_slot,
    input  logic [VAL_W-1:0]  req_amount,
    input  logic [VAL_W-1:0]  req_money,
    output logic              vend_pulse,
    output logic              change_valid,
    output logic [VAL_W-1:0]  change_out,
    output logic              done,
    output logic              red_light,
    output logic [ACC_W-1:0]  machine_acc
);
    localparam int SUM_W = ((ACC_W > 2*VAL_W) ? ACC_W : 2*VAL_W) + 1;
    localparam int CYC_W = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
    typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, CHANGE, REJECT} state_t;
    state_t              r_state, w_next;
    logic [VAL_W-1:0]    r_price  [N_SLOTS];
    logic [VAL_W-1:0]    r_supply [N_SLOTS];
    logic [SLOT_W-1:0]   r_slot;
    logic [VAL_W-1:0]    r_amount, r_money, r_unit, r_change, r_cost;
    logic [ACC_W-1:0]    r_acc;
    logic [CYC_W-1:0]    r_cyc;
    logic                r_red;
    logic [2*VAL_W-1:0]  w_cost;
    logic [SUM_W-1:0]    w_sum;
    logic                w_accept, w_reject, w_unit_end, w_last;

    assign w_cost     = {{VAL_W{1'b0}}, r_price[r_slot]} * {{VAL_W{1'b0}}, r_amount};
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_cost);
    // The cash box is full when the sum spills past ACC_W bits.
    assign w_reject   = (r_amount == '0) || (r_amount > r_supply[r_slot]) ||
                        (w_cost > {{VAL_W{1'b0}}, r_money}) || (w_sum[SUM_W-1:ACC_W] != '0);
    assign w_accept   = req_valid && (r_state == IDLE);
    assign w_unit_end = (r_state == DISPENSE) && (r_cyc == CYC_W'(DISP_CYC - 1));
    assign w_last     = w_unit_end && (r_unit == r_amount - 1'b1);

    assign req_ready    = (r_state == IDLE);
    assign vend_pulse   = w_unit_end;
    assign change_valid = (r_state == CHANGE) || (r_state == REJECT);
    assign done         = change_valid;
    assign change_out   = r_change;
    assign red_light    = r_red;
    assign machine_acc  = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = req_valid ? CHECK : IDLE;
            CHECK:    w_next = w_reject ? REJECT : DISPENSE;
            DISPENSE: w_next = w_last ? CHANGE : DISPENSE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_price[i]  <= '0;
                r_supply[i] <= '0;
            end
            r_slot   <= '0;
            r_amount <= '0;
            r_money  <= '0;
            r_unit   <= '0;
            r_change <= '0;
            r_cost   <= '0;
            r_acc    <= '0;
            r_cyc    <= '0;
            r_red    <= 1'b0;
        end else begin
            if (r_state == IDLE && cfg_we) begin
                r_price[cfg_slot]  <= cfg_price;
                r_supply[cfg_slot] <= cfg_supply;
            end
            if (w_accept) begin
                r_slot   <= req_slot;
                r_amount <= req_amount;
                r_money  <= req_money;
                r_red    <= 1'b0;
            end
            if (r_state == CHECK && w_reject) begin
                r_red    <= 1'b1;
                r_change <= r_money;
            end
            if (r_state == CHECK && !w_reject) begin
                r_acc            <= w_sum[ACC_W-1:0];
                r_supply[r_slot] <= r_supply[r_slot] - r_amount;
                r_cost           <= w_cost[VAL_W-1:0];
                r_unit           <= '0;
                r_cyc            <= '0;
            end
            if (r_state == DISPENSE) begin
                r_cyc  <= w_unit_end ? '0 : r_cyc + 1'b1;
                r_unit <= w_unit_end ? r_unit + 1'b1 : r_unit;
            end
            if (w_last) r_change <= r_money - r_cost;
        end
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed transactions with hand-computed pulse timing, change and account values.
module tb_vend_controller;
    logic       clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, req_valid = 1'b0;
    logic [1:0] cfg_slot = '0, req_slot = '0;
    logic [3:0] cfg_price = '0, cfg_supply = '0, req_amount = '0, req_money = '0;
    logic       req_ready, vend_pulse, change_valid, done, red_light;
    logic [3:0] change_out;
    logic [4:0] machine_acc;
    int         checks = 0, failures = 0;
    int         pulses, done_cyc;
    logic [63:0] pmask;
    logic [3:0] chg;

    vend_controller dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
        .cfg_price(cfg_price), .cfg_supply(cfg_supply), .req_valid(req_valid),
        .req_ready(req_ready), .req_slot(req_slot), .req_amount(req_amount),
        .req_money(req_money), .vend_pulse(vend_pulse), .change_valid(change_valid),
        .change_out(change_out), .done(done), .red_light(red_light), .machine_acc(machine_acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] s, input logic [3:0] p, input logic [3:0] q);
        cfg_we = 1'b1; cfg_slot = s; cfg_price = p; cfg_supply = q;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Cycle 0 is the accept edge; returns once back in IDLE.
    task automatic run(input logic [1:0] s, input logic [3:0] a, input logic [3:0] m);
        int cyc;
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_slot = s; req_amount = a; req_money = m;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1; pulses = 0; pmask = '0; done_cyc = -1; chg = 'x;
        while (cyc < 40 && done_cyc < 0) begin
            if (vend_pulse) begin pulses++; pmask[cyc] = 1'b1; end
            if (done) begin
                done_cyc = cyc; chg = change_out;
                chk("change_valid_with_done", change_valid, 1);
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_txn(input string tag, input int p, input logic [31:0] mk, input int dc,
                             input logic [3:0] c, input logic [4:0] acc, input logic red);
        chk({tag, ".pulses"}, pulses, p);
        chk({tag, ".pulse_cycles"}, pmask[31:0], mk);
        chk({tag, ".done_cycle"}, done_cyc, dc);
        chk({tag, ".change"}, chg, c);
        chk({tag, ".acc"}, machine_acc, acc);
        chk({tag, ".red"}, red_light, red);
        chk({tag, ".change_held"}, change_out, c);
        chk({tag, ".done_one_cycle"}, done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vend", vend_pulse, 0);
        chk("rst.cv", change_valid, 0);
        chk("rst.done", done, 0);
        chk("rst.change", change_out, 0);
        chk("rst.acc", machine_acc, 0);
        chk("rst.red", red_light, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready", req_ready, 1);

        cfg(0, 3, 4);
        run(0, 2, 6);
        check_txn("buy0", 2, 32'h28, 6, 0, 6, 0);
        cfg(1, 4, 5);
        run(1, 3, 15);
        check_txn("buy1", 3, 32'hA8, 8, 3, 18, 0);

        run(0, 2, 5);
        check_txn("rej_money", 0, 0, 2, 5, 18, 1);
        run(0, 3, 9);
        check_txn("rej_supply", 0, 0, 2, 9, 18, 1);
        run(0, 0, 7);
        check_txn("rej_zero", 0, 0, 2, 7, 18, 1);
        run(0, 2, 6);
        check_txn("buy0_again", 2, 32'h28, 6, 0, 24, 0);

        // Table write during DISPENSE must be dropped
        fork
            run(1, 1, 4);
            begin
                @(posedge clk); #1;
                @(posedge clk); #2;
                cfg_we = 1'b1; cfg_slot = 0; cfg_price = 1; cfg_supply = 9;
                @(posedge clk); #1;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join
        check_txn("buy1_cfg_busy", 1, 32'h08, 4, 0, 28, 0);
        run(0, 1, 5);
        check_txn("rej_cfg_ignored", 0, 0, 2, 5, 28, 1);

        // Write and handshake in the same IDLE cycle
        cfg_we = 1'b1; cfg_slot = 0; cfg_price = 2; cfg_supply = 1;
        run(0, 1, 3);
        cfg_we = 1'b0;
        check_txn("cfg_and_req", 1, 32'h08, 4, 1, 30, 0);

        cfg(2, 2, 5);
        run(2, 1, 2);
        check_txn("rej_boxfull", 0, 0, 2, 2, 30, 1);
        cfg(3, 1, 3);
        run(3, 1, 1);
        check_txn("fill_to_31", 1, 32'h08, 4, 0, 31, 0);
        cfg(3, 0, 3);
        run(3, 2, 5);
        check_txn("free_item", 2, 32'h28, 6, 5, 31, 0);

        // Reset in the middle of DISPENSE
        cfg(3, 0, 4);
        req_valid = 1'b1; req_slot = 3; req_amount = 3; req_money = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.first_pulse", vend_pulse, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid.vend", vend_pulse, 0);
        chk("mid.cv", change_valid, 0);
        chk("mid.done", done, 0);
        chk("mid.change", change_out, 0);
        chk("mid.acc", machine_acc, 0);
        chk("mid.red", red_light, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.no_done_in_reset", done, 0);
        rst_n = 1'b1;
        #1;
        chk("mid.ready", req_ready, 1);
        run(3, 1, 0);
        check_txn("after_rst_table_zero", 0, 0, 2, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
